program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter: RAM_BYTES, 16, number of program bytes written per load; power of two, 2..256.
REQ-002 SHALL have parameter: ADDR_W, 4, RAM address width; equals log2(RAM_BYTES).
REQ-003 SHALL have port: clk  input  1  rising-edge clock shared with CPU.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port: start  input  1  begin load; sampled per cycle.
REQ-006 SHALL have port: in_data  input  8  program byte from pins.
REQ-007 SHALL have port: in_valid  input  1  in_data valid.
REQ-008 SHALL have port: in_ready  output  1  loader accepts byte this cycle.
REQ-009 SHALL have port: ram_addr  output  ADDR_W  RAM write address.
REQ-010 SHALL have port: ram_data  output  8  RAM write data.
REQ-011 SHALL have port: ram_we  output  1  RAM write strobe, active-high.
REQ-012 SHALL have port: cpu_run  output  1  CPU released to execute; 0 holds CPU in reset.
REQ-013 SHALL have port: done  output  1  load complete and accepted.
REQ-014 SHALL have port: err  output  1  checksum mismatch (0 when checksum compiled out).

Function
REQ-015 SHALL implement states IDLE, RECV, WRITE, CHECK, DONE, ERROR.
REQ-016 SHALL transfer a byte only in a cycle with in_valid=1 and in_ready=1; in_ready is registered, depends only on state.
REQ-017 SHALL drive in_ready=1 only in RECV and CHECK.
REQ-018 IDLE/DONE/ERROR: start=1 -> RECV next cycle, byte counter=0, running sum=0, done=0, err=0, cpu_run=0.
REQ-019 SHALL ignore start while in RECV, WRITE or CHECK.
REQ-020 RECV: on transfer, capture in_data into ram_data, add to running sum mod 256, go WRITE.
REQ-021 WRITE: ram_we=1 for exactly that one cycle, ram_addr=counter, ram_data=captured byte; throughput one byte per two cycles.
REQ-022 WRITE exit: counter=RAM_BYTES-1 -> CHECK (macro defined) or DONE; otherwise counter+1, RECV.
REQ-023 Counter SHALL never wrap past RAM_BYTES-1 within one load; ram_addr holds last value outside WRITE.
REQ-024 DONE: cpu_run=1, done=1, ram_we=0; held until start.
REQ-025 ERROR: cpu_run=0, done=0, err=1; held until start.
REQ-026 ram_we SHALL be 0 in every state except WRITE.
REQ-027 in_valid low in RECV SHALL stall indefinitely with no state change.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, counter=0, sum=0, ram_addr=0, ram_data=0, ram_we=0, in_ready=0, cpu_run=0, done=0, err=0, including mid-load; partial RAM contents are not cleared.

Configuration
REQ-029 With LOADER_CHECKSUM_EN defined: after last WRITE, CHECK accepts one extra byte; equal to running sum -> DONE, else ERROR; CHECK byte is never written to RAM.
REQ-030 Without LOADER_CHECKSUM_EN: CHECK and ERROR unreachable/omitted, sum register removed, err tied 0, last WRITE -> DONE.

Structure
REQ-031 Shared package SHALL hold the state enumeration and default RAM_BYTES/ADDR_W constants used by the CPU top and RAM.
REQ-032 Single module, no sub-modules; checksum accumulator inline.

Verification
REQ-033 Reset, no start, 20 cycles -> cpu_run=0, ram_we=0, in_ready=0, done=0.
REQ-034 start, stream bytes 0x00..0x0F with in_valid held 1 (macro off) -> 16 ram_we pulses, addr 0..15 data 0x00..0x0F, 2-cycle spacing, done=1 and cpu_run=1 cycle after last WRITE.
REQ-035 Macro on, bytes 0x01 x16 then 0x10 -> done=1, err=0; repeat with checksum 0x11 -> err=1, cpu_run=0, no 17th write.
REQ-036 in_valid deasserted 5 cycles after 3rd byte -> no ram_we during gap, addresses contiguous 0..15 after resume.
REQ-037 rst_n low during WRITE of byte 7 -> outputs reset immediately; new start reloads from addr 0.
REQ-038 start pulsed mid-RECV -> ignored; start in DONE -> cpu_run drops next cycle, reload begins at addr 0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader, CPU top and program RAM.
// State encoding and default RAM geometry live here so every consumer agrees.
package program_loader_pkg;

  localparam int DEF_RAM_BYTES = 16;
  localparam int DEF_ADDR_W    = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/program_loader.sv
// Streams RAM_BYTES program bytes from pins into RAM, then releases the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte before release.
//
// state | meaning
// IDLE  | after reset, CPU held, waiting for start
// RECV  | waiting for next byte (in_ready=1)
// WRITE | one-cycle RAM write strobe for captured byte
// CHECK | waiting for checksum byte (checksum build only)
// DONE  | load accepted, CPU running, waiting for start
// ERROR | checksum mismatch, CPU held, waiting for start
module program_loader
  import program_loader_pkg::*;
#(
  parameter int RAM_BYTES = DEF_RAM_BYTES,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              cpu_run,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] count;
  logic              xfer;
  logic              last;
  logic              idle_like;
  logic              in_ready_nxt;
  logic              ram_we_nxt;
  logic              run_nxt;

  assign xfer      = in_valid & in_ready;
  assign last      = (count == LAST_ADDR);
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERROR);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       err_nxt;
`endif

  // Outputs are registered from the next state so they are glitch-free and
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      ram_we   <= 1'b0;
      cpu_run  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= in_ready_nxt;
      ram_we   <= ram_we_nxt;
      cpu_run  <= run_nxt;
      done     <= run_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nxt = RECV;
      RECV:              if (xfer) state_nxt = WRITE;
      WRITE: begin
        if (last) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (xfer) state_nxt = (in_data == sum) ? DONE : ERROR;
`endif
      default:           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_nxt = (state_nxt == RECV) || (state_nxt == CHECK);
    ram_we_nxt   = (state_nxt == WRITE);
    run_nxt      = (state_nxt == DONE);
`ifdef LOADER_CHECKSUM_EN
    err_nxt      = (state_nxt == ERROR);
`endif
  end

  // ram_addr only moves when entering WRITE, so it holds the last address otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      ram_addr <= '0;
      ram_data <= 8'h00;
    end else begin
      if (idle_like && start) count <= '0;
      if (state == RECV && xfer) ram_data <= in_data;
      if (state == WRITE && !last) count <= count + 1'b1;
      if (state_nxt == WRITE) ram_addr <= count;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= 8'h00;
      err <= 1'b0;
    end else begin
      err <= err_nxt;
      if (idle_like && start) sum <= 8'h00;
      else if (state == RECV && xfer) sum <= sum + in_data;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
